csr_file_m: RTL and testbench

- Parametrised machine-mode CSR file, successor to the single-hart M-mode CSR block.
- Sits beside the decode/execute stage.
  - Serves Zicsr read/write/set/clear accesses.
  - Arbitrates interrupts, including optional platform-local lines.
  - Supplies trap and return PCs, with optional vectored mtvec.
- Adds mscratch, mtval, mip, 64-bit mcycle/minstret, mcountinhibit, and illegal-access detection.

---
 rtl/csr_pkg.sv | 44 ++++
 rtl/csr_file_m_if.sv | 23 ++
 rtl/csr_counter_m.sv | 43 ++++
 rtl/csr_file_m.sv | 210 +++++++++++++++++++++
 tb/tb_csr_file_m.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - shared encodings and constants for the machine-mode CSR file
// Contents: access-type encodings, CSR addresses, interrupt cause codes,
// misa constant and the mtvec mode type. No ports.
package csr_pkg;

    typedef enum logic [1:0] {
        CSR_READ_ONLY = 2'd0,
        CSR_WRITE     = 2'd1,
        CSR_SET       = 2'd2,
        CSR_CLEAR     = 2'd3
    } csr_access_e;

    typedef enum logic {
        MTVEC_DIRECT   = 1'b0,
        MTVEC_VECTORED = 1'b1
    } mtvec_mode_e;

    localparam logic [11:0] CSR_MSTATUS       = 12'h300;
    localparam logic [11:0] CSR_MISA          = 12'h301;
    localparam logic [11:0] CSR_MIE           = 12'h304;
    localparam logic [11:0] CSR_MTVEC         = 12'h305;
    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
    localparam logic [11:0] CSR_MEPC          = 12'h341;
    localparam logic [11:0] CSR_MCAUSE        = 12'h342;
    localparam logic [11:0] CSR_MTVAL         = 12'h343;
    localparam logic [11:0] CSR_MIP           = 12'h344;
    localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
    localparam logic [11:0] CSR_MVENDORID     = 12'hF11;
    localparam logic [11:0] CSR_MARCHID       = 12'hF12;
    localparam logic [11:0] CSR_MIMPID        = 12'hF13;
    localparam logic [11:0] CSR_MHARTID       = 12'hF14;

    localparam logic [4:0] IRQ_MSI        = 5'd3;
    localparam logic [4:0] IRQ_MTI        = 5'd7;
    localparam logic [4:0] IRQ_MEI        = 5'd11;
    localparam logic [4:0] IRQ_LOCAL_BASE = 5'd16;

    localparam logic [31:0] MISA_VALUE = 32'h4000_0100;

endpackage

// File: rtl/csr_file_m_if.sv
// rtl/csr_file_m_if.sv - CSR access bus between decode/execute and the CSR file
// Signals: number (address), access_type, in (operand) from master;
// out (read value) and csr_illegal from slave.
interface csr_file_m_if;
    import csr_pkg::*;

    logic [11:0] number;
    csr_access_e access_type;
    logic [31:0] in;
    logic [31:0] out;
    logic        csr_illegal;

    modport master (
        output number, access_type, in,
        input  out, csr_illegal
    );

    modport slave (
        input  number, access_type, in,
        output out, csr_illegal
    );

endinterface

// File: rtl/csr_counter_m.sv
// rtl/csr_counter_m.sv - WIDTH-bit event counter readable/writable as two 32-bit halves
// Ports: clk, reset_n (async active-low), inc (count event), inhibit,
// wr_lo/wr_hi (CSR write of a half), wdata, lo/hi (read halves, hi zero-extended).
module csr_counter_m #(
    parameter int WIDTH = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        inc,
    input  logic        inhibit,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [31:0] lo,
    output logic [31:0] hi
);

    localparam int HI_W = WIDTH - 32;

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // A write to either half suppresses the increment for that cycle;
    // the half not being written keeps its current value.
    always_comb begin
        cnt_d = cnt_q;
        if (wr_lo || wr_hi) begin
            if (wr_lo) cnt_d[31:0] = wdata;
            if (wr_hi) cnt_d[WIDTH-1:32] = wdata[HI_W-1:0];
        end else if (inc && !inhibit) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign lo = cnt_q[31:0];
    assign hi = 32'(cnt_q[WIDTH-1:32]);

endmodule

// File: rtl/csr_file_m.sv
// rtl/csr_file_m.sv - machine-mode CSR file with interrupt arbitration and trap PCs
// Ports: clk, reset_n (async active-low); csr (CSR access bus, slave side);
// external/timer/software/local_interrupt (level); exception, exception_cause,
// exception_value, handle_trap, exit_trap, instret, current_pc;
// trap_pc, ret_pc (mepc), interrupted.
module csr_file_m
    import csr_pkg::*;
#(
    parameter int          NUM_LOCAL_IRQ = 0,
    parameter int          COUNTER_WIDTH = 64,
    parameter bit          VECTORED_EN   = 1'b1,
    parameter logic [31:0] HART_ID       = 32'd0
) (
    input  logic        clk,
    input  logic        reset_n,
    csr_file_m_if.slave csr,
    input  logic        external_interrupt,
    input  logic        timer_interrupt,
    input  logic        software_interrupt,
    input  logic [(NUM_LOCAL_IRQ > 0 ? NUM_LOCAL_IRQ : 1)-1:0] local_interrupt,
    input  logic        exception,
    input  logic [30:0] exception_cause,
    input  logic [31:0] exception_value,
    input  logic        handle_trap,
    input  logic        exit_trap,
    input  logic        instret,
    input  logic [31:0] current_pc,
    output logic [31:0] trap_pc,
    output logic [31:0] ret_pc,
    output logic        interrupted
);

    // With no local lines the mask is zero, so the unused input bit never reaches mip.
    localparam logic [15:0] LOCAL_MASK = 16'((32'd1 << NUM_LOCAL_IRQ) - 32'd1);
    localparam logic [31:0] MIE_MASK   = {LOCAL_MASK, 16'h0888};

    logic        mstatus_mie;
    logic        mstatus_mpie;
    logic [31:0] mie_q;
    logic [29:0] mtvec_base;
    mtvec_mode_e mtvec_mode;
    logic [31:0] mscratch;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [31:0] mtval;
    logic        cy_inhibit;
    logic        ir_inhibit;

    logic [31:0] mcycle_lo, mcycle_hi, minstret_lo, minstret_hi;

    logic [15:0] local_live;
    logic [31:0] mip_val;
    logic [31:0] pending;
    logic        irq_any;
    logic [4:0]  irq_code;
    logic        take_irq;
    logic [30:0] cause;

    logic [31:0] rd_val;
    logic        implemented;
    logic        illegal;
    logic [31:0] wr_val;
    logic        csr_we;

    assign local_live = 16'(local_interrupt) & LOCAL_MASK;
    assign mip_val    = {local_live, 4'b0, external_interrupt, 3'b0,
                         timer_interrupt, 3'b0, software_interrupt, 3'b0};
    assign pending    = mip_val & mie_q;
    assign irq_any    = |pending;

    // Interrupt priority: MEI > MSI > MTI > lowest-numbered local line.
    always_comb begin
        irq_code = 5'd0;
        if (pending[11])     irq_code = IRQ_MEI;
        else if (pending[3]) irq_code = IRQ_MSI;
        else if (pending[7]) irq_code = IRQ_MTI;
        else begin
            for (int i = 15; i >= 0; i--) begin
                if (pending[16+i]) irq_code = IRQ_LOCAL_BASE + 5'(i);
            end
        end
    end

    assign take_irq    = !exception && irq_any;
    assign cause       = take_irq ? {26'b0, irq_code} : exception_cause;
    assign interrupted = irq_any && mstatus_mie;
    assign ret_pc      = mepc;
    assign trap_pc     = (mtvec_mode == MTVEC_VECTORED && take_irq)
                         ? {mtvec_base, 2'b00} + {25'b0, irq_code, 2'b00}
                         : {mtvec_base, 2'b00};

    always_comb begin
        rd_val      = 32'd0;
        implemented = 1'b1;
        case (csr.number)
            CSR_MSTATUS:       rd_val = {24'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};
            CSR_MISA:          rd_val = MISA_VALUE;
            CSR_MIE:           rd_val = mie_q;
            CSR_MTVEC:         rd_val = {mtvec_base, 1'b0, mtvec_mode};
            CSR_MCOUNTINHIBIT: rd_val = {29'b0, ir_inhibit, 1'b0, cy_inhibit};
            CSR_MSCRATCH:      rd_val = mscratch;
            CSR_MEPC:          rd_val = mepc;
            CSR_MCAUSE:        rd_val = mcause;
            CSR_MTVAL:         rd_val = mtval;
            CSR_MIP:           rd_val = mip_val;
            CSR_MCYCLE:        rd_val = mcycle_lo;
            CSR_MCYCLEH:       rd_val = mcycle_hi;
            CSR_MINSTRET:      rd_val = minstret_lo;
            CSR_MINSTRETH:     rd_val = minstret_hi;
            CSR_MVENDORID,
            CSR_MARCHID,
            CSR_MIMPID:        rd_val = 32'd0;
            CSR_MHARTID:       rd_val = HART_ID;
            default:           implemented = 1'b0;
        endcase
    end

    assign illegal = !implemented ||
                     (csr.number[11:10] == 2'b11 && csr.access_type != CSR_READ_ONLY);
    assign csr.out         = rd_val;
    assign csr.csr_illegal = illegal;

    always_comb begin
        case (csr.access_type)
            CSR_WRITE: wr_val = csr.in;
            CSR_SET:   wr_val = rd_val | csr.in;
            CSR_CLEAR: wr_val = rd_val & ~csr.in;
            default:   wr_val = rd_val;
        endcase
    end

    // Trap entry and mret both take precedence over a software CSR write.
    assign csr_we = csr.access_type != CSR_READ_ONLY && !illegal && !handle_trap && !exit_trap;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mie_q        <= 32'd0;
            mtvec_base   <= 30'd0;
            mtvec_mode   <= MTVEC_DIRECT;
            mscratch     <= 32'd0;
            mepc         <= 32'd0;
            mcause       <= 32'd0;
            mtval        <= 32'd0;
            cy_inhibit   <= 1'b0;
            ir_inhibit   <= 1'b0;
        end else if (handle_trap) begin
            mepc         <= current_pc;
            mstatus_mpie <= mstatus_mie;
            mstatus_mie  <= 1'b0;
            mcause       <= {!exception, cause};
            mtval        <= exception ? exception_value : 32'd0;
        end else if (exit_trap) begin
            mstatus_mie  <= mstatus_mpie;
            mstatus_mpie <= 1'b1;
        end else if (csr_we) begin
            case (csr.number)
                CSR_MSTATUS: begin
                    mstatus_mie  <= wr_val[3];
                    mstatus_mpie <= wr_val[7];
                end
                CSR_MIE: mie_q <= wr_val & MIE_MASK;
                CSR_MTVEC: begin
                    mtvec_base <= wr_val[31:2];
                    // Reserved MODE encodings leave the current mode in place.
                    case (wr_val[1:0])
                        2'b00:   mtvec_mode <= MTVEC_DIRECT;
                        2'b01:   mtvec_mode <= VECTORED_EN ? MTVEC_VECTORED : MTVEC_DIRECT;
                        default: mtvec_mode <= mtvec_mode;
                    endcase
                end
                CSR_MCOUNTINHIBIT: begin
                    cy_inhibit <= wr_val[0];
                    ir_inhibit <= wr_val[2];
                end
                CSR_MSCRATCH: mscratch <= wr_val;
                CSR_MEPC:     mepc     <= wr_val;
                CSR_MCAUSE:   mcause   <= wr_val;
                CSR_MTVAL:    mtval    <= wr_val;
                default: ;
            endcase
        end
    end

    csr_counter_m #(.WIDTH(COUNTER_WIDTH)) u_mcycle (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (1'b1),
        .inhibit (cy_inhibit),
        .wr_lo   (csr_we && csr.number == CSR_MCYCLE),
        .wr_hi   (csr_we && csr.number == CSR_MCYCLEH),
        .wdata   (wr_val),
        .lo      (mcycle_lo),
        .hi      (mcycle_hi)
    );

    csr_counter_m #(.WIDTH(COUNTER_WIDTH)) u_minstret (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (instret),
        .inhibit (ir_inhibit),
        .wr_lo   (csr_we && csr.number == CSR_MINSTRET),
        .wr_hi   (csr_we && csr.number == CSR_MINSTRETH),
        .wdata   (wr_val),
        .lo      (minstret_lo),
        .hi      (minstret_hi)
    );

endmodule

// File: tb/tb_csr_file_m.sv
// tb/tb_csr_file_m.sv - directed self-checking bench for csr_file_m
module tb_csr_file_m;
    import csr_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        external_interrupt, timer_interrupt, software_interrupt;
    logic [3:0]  local_interrupt;
    logic        exception;
    logic [30:0] exception_cause;
    logic [31:0] exception_value;
    logic        handle_trap, exit_trap, instret;
    logic [31:0] current_pc;
    logic [31:0] trap_pc, ret_pc;
    logic        interrupted;
    logic        ill;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    csr_file_m_if bus ();

    csr_file_m #(
        .NUM_LOCAL_IRQ (4),
        .COUNTER_WIDTH (64),
        .VECTORED_EN   (1'b1),
        .HART_ID       (32'd5)
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .csr                (bus),
        .external_interrupt (external_interrupt),
        .timer_interrupt    (timer_interrupt),
        .software_interrupt (software_interrupt),
        .local_interrupt    (local_interrupt),
        .exception          (exception),
        .exception_cause    (exception_cause),
        .exception_value    (exception_value),
        .handle_trap        (handle_trap),
        .exit_trap          (exit_trap),
        .instret            (instret),
        .current_pc         (current_pc),
        .trap_pc            (trap_pc),
        .ret_pc             (ret_pc),
        .interrupted        (interrupted)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic csr_wr(input logic [11:0] a, input csr_access_e t, input logic [31:0] d,
                          output logic illegal);
        bus.number      = a;
        bus.access_type = t;
        bus.in          = d;
        #1;
        illegal = bus.csr_illegal;
        tick();
        bus.access_type = CSR_READ_ONLY;
    endtask

    task automatic rchk(input string tag, input logic [11:0] a, input logic [31:0] exp);
        bus.number      = a;
        bus.access_type = CSR_READ_ONLY;
        #1;
        chk(tag, bus.out, exp);
    endtask

    task automatic do_trap;
        handle_trap = 1'b1;
        tick();
        handle_trap = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        external_interrupt = 0; timer_interrupt = 0; software_interrupt = 0;
        local_interrupt = 4'b0; exception = 0; exception_cause = '0;
        exception_value = '0; handle_trap = 0; exit_trap = 0; instret = 0;
        current_pc = '0;
        bus.number = CSR_MSTATUS; bus.access_type = CSR_READ_ONLY; bus.in = '0;
        repeat (3) tick();

        // reset state
        rchk("rst_misa", CSR_MISA, 32'h4000_0100);
        rchk("rst_mhartid", CSR_MHARTID, 32'd5);
        rchk("rst_mstatus", CSR_MSTATUS, 32'h0);
        rchk("rst_mcycle", CSR_MCYCLE, 32'h0);
        chk("rst_trap_pc", trap_pc, 32'h0);
        chk("rst_ret_pc", ret_pc, 32'h0);
        chk("rst_interrupted", {31'b0, interrupted}, 32'h0);
        bus.number = 12'h7C0; #1;
        chk("rst_illegal_unimpl", {31'b0, bus.csr_illegal}, 32'h1);
        tick();
        reset_n = 1'b1;
        tick();

        // vectored mtvec + timer interrupt
        csr_wr(CSR_MTVEC, CSR_WRITE, 32'h8000_0001, ill);
        rchk("mtvec_rd", CSR_MTVEC, 32'h8000_0001);
        csr_wr(CSR_MIE, CSR_WRITE, 32'h0000_0080, ill);
        csr_wr(CSR_MSTATUS, CSR_WRITE, 32'h0000_0008, ill);
        timer_interrupt = 1'b1;
        current_pc = 32'h0000_1234;
        #1;
        chk("tmr_interrupted", {31'b0, interrupted}, 32'h1);
        chk("tmr_trap_pc", trap_pc, 32'h8000_001C);
        do_trap();
        timer_interrupt = 1'b0;
        rchk("tmr_mcause", CSR_MCAUSE, 32'h8000_0007);
        rchk("tmr_mstatus", CSR_MSTATUS, 32'h0000_0080);
        chk("tmr_mepc", ret_pc, 32'h0000_1234);

        // counters
        instret = 1'b1;
        repeat (3) tick();
        instret = 1'b0;
        rchk("minstret", CSR_MINSTRET, 32'd3);
        csr_wr(CSR_MCYCLE, CSR_WRITE, 32'hFFFF_FFFF, ill);
        csr_wr(CSR_MCYCLEH, CSR_WRITE, 32'h0, ill);
        tick();
        tick();
        rchk("mcycle_wrap_lo", CSR_MCYCLE, 32'h0000_0001);
        rchk("mcycle_wrap_hi", CSR_MCYCLEH, 32'h0000_0001);
        csr_wr(CSR_MCOUNTINHIBIT, CSR_WRITE, 32'h1, ill);
        repeat (3) tick();
        rchk("mcycle_frozen_lo", CSR_MCYCLE, 32'h0000_0002);
        rchk("mcycle_frozen_hi", CSR_MCYCLEH, 32'h0000_0001);

        // interrupt priority
        csr_wr(CSR_MIE, CSR_WRITE, 32'hFFFF_FFFF, ill);
        rchk("mie_mask", CSR_MIE, 32'h000F_0888);
        csr_wr(CSR_MIE, CSR_WRITE, 32'h0004_0888, ill);
        external_interrupt = 1; software_interrupt = 1; timer_interrupt = 1;
        local_interrupt = 4'b0100;
        rchk("mip_live", CSR_MIP, 32'h0004_0888);
        chk("prio_mie_gate", {31'b0, interrupted}, 32'h0);
        csr_wr(CSR_MSTATUS, CSR_SET, 32'h8, ill);
        chk("prio_interrupted", {31'b0, interrupted}, 32'h1);
        chk("prio_trap_pc_mei", trap_pc, 32'h8000_002C);
        do_trap();
        rchk("prio_mei", CSR_MCAUSE, 32'h8000_000B);
        rchk("prio_mtval", CSR_MTVAL, 32'h0);
        csr_wr(CSR_MIE, CSR_CLEAR, 32'h800, ill);
        do_trap();
        rchk("prio_msi", CSR_MCAUSE, 32'h8000_0003);
        csr_wr(CSR_MIE, CSR_CLEAR, 32'h8, ill);
        do_trap();
        rchk("prio_mti", CSR_MCAUSE, 32'h8000_0007);
        csr_wr(CSR_MIE, CSR_CLEAR, 32'h80, ill);
        chk("prio_trap_pc_local", trap_pc, 32'h8000_0048);
        do_trap();
        rchk("prio_local2", CSR_MCAUSE, 32'h8000_0012);

        // exception trap and mret
        external_interrupt = 0; software_interrupt = 0; timer_interrupt = 0;
        csr_wr(CSR_MSTATUS, CSR_WRITE, 32'h8, ill);
        exception = 1'b1; exception_cause = 31'd2; exception_value = 32'hDEAD_BEEF;
        current_pc = 32'h0000_0400;
        #1;
        chk("exc_trap_pc", trap_pc, 32'h8000_0000);
        do_trap();
        exception = 1'b0;
        rchk("exc_mcause", CSR_MCAUSE, 32'h0000_0002);
        rchk("exc_mtval", CSR_MTVAL, 32'hDEAD_BEEF);
        rchk("exc_mstatus", CSR_MSTATUS, 32'h0000_0080);
        chk("exc_mepc", ret_pc, 32'h0000_0400);
        exit_trap = 1'b1;
        tick();
        exit_trap = 1'b0;
        rchk("mret_mstatus", CSR_MSTATUS, 32'h0000_0088);
        local_interrupt = 4'b0;

        // illegal accesses and WARL fields
        csr_wr(CSR_MSCRATCH, CSR_WRITE, 32'h1234_5678, ill);
        csr_wr(CSR_MHARTID, CSR_WRITE, 32'h55, ill);
        chk("ill_wr_mhartid", {31'b0, ill}, 32'h1);
        rchk("mhartid_rd", CSR_MHARTID, 32'd5);
        chk("mhartid_rd_legal", {31'b0, bus.csr_illegal}, 32'h0);
        csr_wr(12'h7C0, CSR_WRITE, 32'hFFFF_FFFF, ill);
        chk("ill_wr_unimpl", {31'b0, ill}, 32'h1);
        rchk("mscratch_kept", CSR_MSCRATCH, 32'h1234_5678);
        csr_wr(CSR_MSCRATCH, CSR_CLEAR, 32'h0000_FFFF, ill);
        rchk("mscratch_clear", CSR_MSCRATCH, 32'h1234_0000);
        csr_wr(CSR_MIP, CSR_WRITE, 32'hFFFF_FFFF, ill);
        chk("mip_wr_legal", {31'b0, ill}, 32'h0);
        rchk("mip_wr_ignored", CSR_MIP, 32'h0);
        csr_wr(CSR_MTVEC, CSR_WRITE, 32'h4000_0002, ill);
        rchk("mtvec_mode_keep", CSR_MTVEC, 32'h4000_0001);

        // simultaneous trap, mret and CSR write
        exception = 1'b1; exception_cause = 31'd5; current_pc = 32'h0000_2000;
        handle_trap = 1'b1; exit_trap = 1'b1;
        csr_wr(CSR_MSTATUS, CSR_WRITE, 32'h0, ill);
        handle_trap = 1'b0; exit_trap = 1'b0; exception = 1'b0;
        rchk("prio_all_mstatus", CSR_MSTATUS, 32'h0000_0080);
        rchk("prio_all_mcause", CSR_MCAUSE, 32'h0000_0005);
        chk("prio_all_mepc", ret_pc, 32'h0000_2000);

        // asynchronous reset mid-sequence
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        rchk("arst_mscratch", CSR_MSCRATCH, 32'h0);
        rchk("arst_mstatus", CSR_MSTATUS, 32'h0);
        rchk("arst_mcycleh", CSR_MCYCLEH, 32'h0);
        rchk("arst_mtvec", CSR_MTVEC, 32'h0);
        chk("arst_ret_pc", ret_pc, 32'h0);
        tick();
        reset_n = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
